// File: rtl/bp_resolve.sv
// Branch-resolution unit: queues fetch-stage predictions in order and checks
// them against execute-stage outcomes, training the predictor on a miss.
// Latency: mispred/t_addr/tp_addr/redirect_pc are registered, 1 cycle after
// the resolving edge. Backpressure: push_ready drops when the queue is full
// and during the mispredict cycle; res_valid is never stalled.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   push_*                   fetch prediction (pc, hit, taken, paddr), valid/ready
//   res_*                    resolution of the oldest queued instruction
//   flush                    external flush, empties the queue
//   mispred, t_addr, tp_addr training pulse to the predictor
//   redirect_pc              correct next PC for the front end
//   count                    queue occupancy
//   proto_err                sticky: resolve seen with an empty queue
//   n_resolved, n_mispred    wrapping event counters
module bp_resolve #(
   parameter int N = 3
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push_valid,
   output logic         push_ready,
   input  logic [31:0]  push_pc,
   input  logic         push_hit,
   input  logic         push_taken,
   input  logic [31:0]  push_paddr,
   input  logic         res_valid,
   input  logic         res_is_br,
   input  logic         res_taken,
   input  logic [31:0]  res_target,
   input  logic         flush,
   output logic         mispred,
   output logic [31:0]  t_addr,
   output logic [31:0]  tp_addr,
   output logic [31:0]  redirect_pc,
   output logic [N:0]   count,
   output logic         proto_err,
   output logic [31:0]  n_resolved,
   output logic [31:0]  n_mispred
);

   localparam int DEPTH = 1 << N;

   // Prediction storage; written only, never reset (contents gated by count).
   logic [31:0] pc_mem    [DEPTH];
   logic [31:0] paddr_mem [DEPTH];
   logic        hit_mem   [DEPTH];
   logic        taken_mem [DEPTH];

   logic [N-1:0] rd_ptr;
   logic [N-1:0] wr_ptr;

   logic        empty;
   logic        full;
   logic [31:0] h_pc;
   logic [31:0] h_paddr;
   logic        pred_t;
   logic        act_t;
   logic        wrong;
   logic [31:0] pc_plus4;
   logic [31:0] next_pc;
   logic [31:0] train_tgt;
   logic        do_pop;
   logic        do_push;
   logic        squash;
   logic        err_evt;

   assign empty = (count == '0);
   assign full  = (count == (N+1)'(DEPTH));

   // The cycle after a mispredict is a dead cycle for the front end, so
   // fetch is held off even if there is room.
   assign push_ready = !full && !mispred;

   assign h_pc    = pc_mem[rd_ptr];
   assign h_paddr = paddr_mem[rd_ptr];
   assign pred_t  = hit_mem[rd_ptr] & taken_mem[rd_ptr];
   assign act_t   = res_is_br & res_taken;

   // A taken branch needs both the direction and the target right; anything
   // else (not-taken branch, non-branch) is wrong only if it was predicted taken.
   assign wrong     = act_t ? (!pred_t || (h_paddr != res_target)) : pred_t;
   assign pc_plus4  = h_pc + 32'd4;
   assign next_pc   = act_t ? res_target : pc_plus4;
   assign train_tgt = res_is_br ? res_target : pc_plus4;

   // flush beats everything; the mispred cycle ignores both request sides.
   assign do_pop  = res_valid && !empty && !mispred && !flush;
   assign squash  = do_pop && wrong;
   assign do_push = push_valid && push_ready && !flush && !squash;
   assign err_evt = res_valid && empty && !mispred && !flush;

   always_ff @(posedge clk) begin
      if (do_push) begin
         pc_mem[wr_ptr]    <= push_pc;
         paddr_mem[wr_ptr] <= push_paddr;
         hit_mem[wr_ptr]   <= push_hit;
         taken_mem[wr_ptr] <= push_taken;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         mispred     <= 1'b0;
         t_addr      <= '0;
         tp_addr     <= '0;
         redirect_pc <= '0;
         proto_err   <= 1'b0;
         n_resolved  <= '0;
         n_mispred   <= '0;
      end else begin
         mispred <= squash;

         if (do_pop) begin
            n_resolved <= n_resolved + 32'd1;
         end

         if (squash) begin
            n_mispred   <= n_mispred + 32'd1;
            t_addr      <= h_pc;
            tp_addr     <= train_tgt;
            redirect_pc <= next_pc;
         end

         if (err_evt) begin
            proto_err <= 1'b1;
         end

         // Everything behind a mispredicted head is wrong-path: drop it all.
         if (flush || squash) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bp_resolve.sv
module tb_bp_resolve;

   localparam int N = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         push_valid = 1'b0;
   logic         push_ready;
   logic [31:0]  push_pc = '0;
   logic         push_hit = 1'b0;
   logic         push_taken = 1'b0;
   logic [31:0]  push_paddr = '0;
   logic         res_valid = 1'b0;
   logic         res_is_br = 1'b0;
   logic         res_taken = 1'b0;
   logic [31:0]  res_target = '0;
   logic         flush = 1'b0;
   logic         mispred;
   logic [31:0]  t_addr;
   logic [31:0]  tp_addr;
   logic [31:0]  redirect_pc;
   logic [N:0]   count;
   logic         proto_err;
   logic [31:0]  n_resolved;
   logic [31:0]  n_mispred;

   bp_resolve #(.N(N)) dut (
      .clk(clk), .rst(rst),
      .push_valid(push_valid), .push_ready(push_ready), .push_pc(push_pc),
      .push_hit(push_hit), .push_taken(push_taken), .push_paddr(push_paddr),
      .res_valid(res_valid), .res_is_br(res_is_br), .res_taken(res_taken),
      .res_target(res_target), .flush(flush),
      .mispred(mispred), .t_addr(t_addr), .tp_addr(tp_addr),
      .redirect_pc(redirect_pc), .count(count), .proto_err(proto_err),
      .n_resolved(n_resolved), .n_mispred(n_mispred)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        mis;
      logic [31:0] t;
      logic [31:0] tp;
      logic [31:0] rd;
      logic [31:0] nmis;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_nmis = '0;
   logic [31:0] prev_res = '0;
   logic [31:0] tgt_q[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
      end
   endtask

   // Monitor: every increment of n_resolved is one pop; compare it against
   // the oldest expectation queued by the stimulus.
   always @(negedge clk) begin
      if (rst) begin
         prev_res = '0;
      end else if (n_resolved != prev_res) begin
         prev_res = n_resolved;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_resolve: got n_resolved %0d expected no pop", n_resolved);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("mon_mispred", {31'd0, mispred}, {31'd0, e.mis});
            if (e.mis) begin
               chk("mon_t_addr", t_addr, e.t);
               chk("mon_tp_addr", tp_addr, e.tp);
               chk("mon_redirect_pc", redirect_pc, e.rd);
            end
            chk("mon_n_mispred", n_mispred, e.nmis);
         end
      end else if (mispred) begin
         checks++;
         errors++;
         $display("FAIL spurious_mispred: got 1 expected 0");
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_in();
      push_valid = 1'b0; push_pc = '0; push_hit = 1'b0; push_taken = 1'b0; push_paddr = '0;
      res_valid = 1'b0; res_is_br = 1'b0; res_taken = 1'b0; res_target = '0; flush = 1'b0;
   endtask

   task automatic do_push(input logic [31:0] pc, input logic hit, input logic tk, input logic [31:0] pa);
      push_valid = 1'b1; push_pc = pc; push_hit = hit; push_taken = tk; push_paddr = pa;
      step();
      clear_in();
   endtask

   // Issues one resolve and queues its hand-computed expected response.
   task automatic do_res(input logic br, input logic tk, input logic [31:0] tgt,
                         input logic mis, input logic [31:0] t, input logic [31:0] tp,
                         input logic [31:0] rd);
      exp_t e;
      if (mis) exp_nmis = exp_nmis + 32'd1;
      e.mis = mis; e.t = t; e.tp = tp; e.rd = rd; e.nmis = exp_nmis;
      exp_q.push_back(e);
      res_valid = 1'b1; res_is_br = br; res_taken = tk; res_target = tgt;
      step();
      clear_in();
   endtask

   initial begin
      logic [31:0] nres_snap;
      // Reset state
      step(); step();
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_push_ready", {31'd0, push_ready}, 32'd1);
      chk("rst_mispred", {31'd0, mispred}, 32'd0);
      chk("rst_proto_err", {31'd0, proto_err}, 32'd0);
      chk("rst_n_resolved", n_resolved, 32'd0);
      chk("rst_n_mispred", n_mispred, 32'd0);
      chk("rst_redirect_pc", redirect_pc, 32'd0);
      chk("rst_t_addr", t_addr, 32'd0);
      rst = 1'b0;
      step();

      // Correct prediction
      do_push(32'h100, 1'b1, 1'b1, 32'h200);
      do_res(1'b1, 1'b1, 32'h200, 1'b0, 32'h0, 32'h0, 32'h0);
      chk("ok_count", 32'(count), 32'd0);
      chk("ok_n_resolved", n_resolved, 32'd1);
      step();

      // Taken branch that missed in the predictor
      do_push(32'h104, 1'b0, 1'b0, 32'h0);
      do_res(1'b1, 1'b1, 32'h400, 1'b1, 32'h104, 32'h400, 32'h400);
      step();

      // Wrong target: younger entries and a same-cycle push are squashed
      do_push(32'h108, 1'b1, 1'b1, 32'h500);
      do_push(32'h50C, 1'b0, 1'b0, 32'h0);
      do_push(32'h510, 1'b0, 1'b0, 32'h0);
      chk("sq_count_before", 32'(count), 32'd3);
      push_valid = 1'b1; push_pc = 32'h514;
      do_res(1'b1, 1'b1, 32'h600, 1'b1, 32'h108, 32'h600, 32'h600);
      chk("sq_count_after", 32'(count), 32'd0);
      chk("sq_push_ready", {31'd0, push_ready}, 32'd0);
      // Requests during the mispred cycle are ignored
      push_valid = 1'b1; push_pc = 32'h518; res_valid = 1'b1;
      step();
      clear_in();
      chk("sq_ignored_count", 32'(count), 32'd0);
      chk("sq_ignored_proto", {31'd0, proto_err}, 32'd0);
      chk("sq_ready_back", {31'd0, push_ready}, 32'd1);

      // Predicted taken, actually not taken
      do_push(32'h7FC, 1'b1, 1'b1, 32'h900);
      do_res(1'b1, 1'b0, 32'hABC, 1'b1, 32'h7FC, 32'hABC, 32'h800);
      step();

      // Non-branch false hit: train toward pc+4
      do_push(32'h300, 1'b1, 1'b1, 32'h340);
      do_res(1'b0, 1'b0, 32'hDEAD, 1'b1, 32'h300, 32'h304, 32'h304);
      step();

      // Correct not-taken prediction (hit, not taken) -> no training
      do_push(32'h310, 1'b1, 1'b0, 32'h999);
      do_res(1'b1, 1'b0, 32'h999, 1'b0, 32'h0, 32'h0, 32'h0);
      chk("hold_redirect_pc", redirect_pc, 32'h304);

      // Full queue and pointer wrap; resolve targets only match if order holds
      for (int i = 0; i < 4; i++) begin
         do_push(32'h1000 + 32'(4*i), 1'b1, 1'b1, 32'h2000 + 32'(4*i));
         tgt_q.push_back(32'h2000 + 32'(4*i));
      end
      chk("full_count", 32'(count), 32'd4);
      chk("full_push_ready", {31'd0, push_ready}, 32'd0);
      push_valid = 1'b1; push_pc = 32'hBAD0; push_hit = 1'b1; push_taken = 1'b1;
      step();
      clear_in();
      chk("full_refused", 32'(count), 32'd4);
      for (int i = 0; i < 6; i++) begin
         if (i == 0) begin
            push_valid = 1'b1; push_pc = 32'hBAD4; push_hit = 1'b1; push_taken = 1'b1;
         end
         do_res(1'b1, 1'b1, tgt_q.pop_front(), 1'b0, 32'h0, 32'h0, 32'h0);
         chk("wrap_pop_count", 32'(count), 32'd3);
         do_push(32'h1100 + 32'(4*i), 1'b1, 1'b1, 32'h2100 + 32'(4*i));
         tgt_q.push_back(32'h2100 + 32'(4*i));
         chk("wrap_push_count", 32'(count), 32'd4);
      end
      for (int i = 0; i < 4; i++) begin
         do_res(1'b1, 1'b1, tgt_q.pop_front(), 1'b0, 32'h0, 32'h0, 32'h0);
      end
      chk("drain_count", 32'(count), 32'd0);
      chk("drain_n_resolved", n_resolved, 32'd16);

      // Resolve with empty queue -> sticky protocol error
      res_valid = 1'b1; res_is_br = 1'b1; res_taken = 1'b1;
      step();
      clear_in();
      chk("proto_set", {31'd0, proto_err}, 32'd1);
      step(); step();
      chk("proto_sticky", {31'd0, proto_err}, 32'd1);

      // Flush with entries plus a same-cycle (would-be-wrong) resolve and push
      do_push(32'h800, 1'b0, 1'b0, 32'h0);
      do_push(32'h804, 1'b0, 1'b0, 32'h0);
      do_push(32'h808, 1'b0, 1'b0, 32'h0);
      nres_snap = n_resolved;
      flush = 1'b1; res_valid = 1'b1; res_is_br = 1'b1; res_taken = 1'b1; res_target = 32'hF00;
      push_valid = 1'b1; push_pc = 32'h80C;
      step();
      clear_in();
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_mispred", {31'd0, mispred}, 32'd0);
      chk("flush_n_resolved", n_resolved, nres_snap);
      step();

      // Asynchronous reset in the middle of a mispred pulse
      do_push(32'h600, 1'b0, 1'b0, 32'h0);
      res_valid = 1'b1; res_is_br = 1'b1; res_taken = 1'b1; res_target = 32'h700;
      step();
      clear_in();
      chk("pulse_before_rst", {31'd0, mispred}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_mispred", {31'd0, mispred}, 32'd0);
      chk("rst_mid_proto", {31'd0, proto_err}, 32'd0);
      chk("rst_mid_n_mispred", n_mispred, 32'd0);
      chk("rst_mid_t_addr", t_addr, 32'd0);
      step();
      rst = 1'b0;
      step(); step();

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL leftover_expect: got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
